// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encoding, owner codes and counter width shared by the arbiter files.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, FETCH = 2'd2} arbState;
  // Owner codes share the busy-state encoding so a grant maps straight onto the next state.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DATA = 2'd1;
  localparam logic [1:0] OWN_FETCH = 2'd2;
  localparam int CNT_W = 16;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: loadable down-counter; expired flags the last allowed busy cycle of a memory wait.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);
  logic [CNT_W-1:0] waitCnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) waitCnt <= '0;
    else if (load) waitCnt <= CNT_W'(TIMEOUT);
    else if (tick && waitCnt != '0) waitCnt <= waitCnt - 1'b1;
  assign expired = tick && waitCnt == CNT_W'(1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports, one access at a time.
// Define ARB_FETCH_BUF_EN to add a one-entry fetch buffer that serves repeat fetches without memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_stall,
  output logic              arb_err
);
  arbState state;
  logic [CNT_W-1:0] burstCnt;
  logic [1:0] grantOwn;
  logic busy, expired, bufHit, burstFull;
  assign busy = state != IDLE;
  assign burstFull = burstCnt == CNT_W'(MAX_DATA_BURST);
  assign arb_stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);
  assign grantOwn = busy ? OWN_NONE :
                    (dm_req && !(if_req && burstFull)) ? OWN_DATA :
                    (if_req && !bufHit) ? OWN_FETCH : OWN_NONE;
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk(clk),
    .reset(reset),
    .load(grantOwn != OWN_NONE),
    .tick(busy),
    .expired(expired)
  );
`ifdef ARB_FETCH_BUF_EN
  logic bufValid;
  logic [ADDR_W-1:0] bufAddr;
  logic [DATA_W-1:0] bufWord;
  assign bufHit = !busy && if_req && bufValid && if_addr == bufAddr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bufValid <= 1'b0;
      bufAddr <= '0;
      bufWord <= '0;
    end else if (state == FETCH && mem_ack) begin
      bufValid <= 1'b1;
      bufAddr <= mem_addr;
      bufWord <= mem_rdata;
    end else if (expired || (grantOwn == OWN_DATA && dm_we && dm_addr[ADDR_W-1:2] == bufAddr[ADDR_W-1:2]))
      bufValid <= 1'b0;
`else
  assign bufHit = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      arb_err <= 1'b0;
      burstCnt <= '0;
    end else begin
      if_ready <= bufHit;
      dm_ready <= 1'b0;
      burstCnt <= (grantOwn == OWN_FETCH || !if_req) ? '0 :
                  (grantOwn == OWN_DATA && !burstFull) ? burstCnt + 1'b1 : burstCnt;
`ifdef ARB_FETCH_BUF_EN
      if (bufHit) if_rdata <= bufWord;
`endif
      if (grantOwn != OWN_NONE) begin
        state <= arbState'(grantOwn);
        mem_req <= 1'b1;
        mem_we <= grantOwn == OWN_DATA && dm_we;
        mem_addr <= grantOwn == OWN_DATA ? dm_addr : if_addr;
        if (grantOwn == OWN_DATA) mem_wdata <= dm_wdata;
      end else if (busy && (mem_ack || expired)) begin
        // An ack on the final watchdog cycle still counts as a good completion.
        state <= IDLE;
        mem_req <= 1'b0;
        mem_we <= 1'b0;
        arb_err <= arb_err | ~mem_ack;
        if (state == DATA) begin
          dm_ready <= 1'b1;
          if (!mem_we) dm_rdata <= mem_ack ? mem_rdata : '0;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= mem_ack ? mem_rdata : '0;
        end
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized two-requester run against a memory model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 8;
  localparam int MAXB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic if_ready;
  logic dm_req = 1'b0;
  logic dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic dm_ready;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_ack;
  logic [DW-1:0] mem_rdata;
  logic arb_stall, arb_err;
  int nVec = 0;
  int nErr = 0;
  int memWait = 0;
  bit memOn = 1'b1;
  bit forceAck = 1'b0;
  bit randWait = 1'b0;
  logic [DW-1:0] tbMem[logic [AW-1:0]];
  logic [DW-1:0] refMem[logic [AW-1:0]];
  logic [AW:0] accLog[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .arb_stall(arb_stall), .arb_err(arb_err)
  );

  function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  // Memory model: acks memWait cycles after the first request cycle, logs each new access.
  initial begin
    int w;
    w = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      if (reset || !mem_req) w = 0;
      else begin
        w++;
        if (w == 1) accLog.push_back({mem_we, mem_addr});
        if (memOn && w == memWait + 1) begin
          mem_ack = 1'b1;
          if (mem_we) tbMem[mem_addr] = mem_wdata;
          else mem_rdata = tbMem.exists(mem_addr) ? tbMem[mem_addr] : initWord(mem_addr);
          if (randWait) memWait = $urandom_range(0, 2);
        end
      end
      if (forceAck) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d vectors applied", nVec);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    nVec++;
    if ({mem_req, mem_we, if_ready, dm_ready, arb_err, arb_stall} !== 6'b0) begin
      nErr++;
      $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, if_ready, dm_ready, arb_err, arb_stall});
    end
    nVec++;
    if ({mem_addr, mem_wdata} !== '0) begin
      nErr++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    nVec++;
    if ({if_rdata, dm_rdata} !== '0) begin
      nErr++;
      $display("FAIL reset_rdata: got if %h dm %h want 0", if_rdata, dm_rdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_load();
    tbMem[32'h100] = 32'hDEAD_BEEF;
    dm_we = 1'b0;
    dm_addr = 32'h100;
    dm_req = 1'b1;
    tick();
    nVec++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin
      nErr++;
      $display("FAIL zw_issue: got req %b we %b addr %h want 1 0 00000100", mem_req, mem_we, mem_addr);
    end
    nVec++;
    if ({dm_ready, arb_stall} !== 2'b01) begin
      nErr++;
      $display("FAIL zw_stall_t1: got ready/stall %b want 01", {dm_ready, arb_stall});
    end
    tick();
    nVec++;
    if ({dm_ready, arb_stall} !== 2'b10) begin
      nErr++;
      $display("FAIL zw_ready_t2: got ready/stall %b want 10", {dm_ready, arb_stall});
    end
    nVec++;
    if (dm_rdata !== 32'hDEAD_BEEF) begin
      nErr++;
      $display("FAIL zw_rdata: got %h want deadbeef", dm_rdata);
    end
    dm_req = 1'b0;
    tick();
    nVec++;
    if ({dm_ready, mem_req} !== 2'b00) begin
      nErr++;
      $display("FAIL zw_one_pulse: got ready/req %b want 00", {dm_ready, mem_req});
    end
  endtask

  task automatic test_simultaneous();
    if_addr = 32'h0;
    if_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 32'h200;
    dm_wdata = 32'h55;
    dm_req = 1'b1;
    tick();
    nVec++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h200, 32'h55}) begin
      nErr++;
      $display("FAIL sim_store_first: got req %b we %b addr %h wdata %h want 1 1 200 55", mem_req, mem_we, mem_addr, mem_wdata);
    end
    tick();
    nVec++;
    if ({dm_ready, if_ready, arb_stall} !== 3'b101) begin
      nErr++;
      $display("FAIL sim_store_done: got dm/if/stall %b want 101", {dm_ready, if_ready, arb_stall});
    end
    dm_req = 1'b0;
    dm_we = 1'b0;
    tick();
    nVec++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h0}) begin
      nErr++;
      $display("FAIL sim_fetch_next: got req %b we %b addr %h want 1 0 0", mem_req, mem_we, mem_addr);
    end
    tick();
    nVec++;
    if ({if_ready, arb_stall, if_rdata} !== {2'b10, refRead(32'h0)}) begin
      nErr++;
      $display("FAIL sim_fetch_done: got ready %b stall %b data %h want 1 0 %h", if_ready, arb_stall, if_rdata, refRead(32'h0));
    end
    nVec++;
    if (!tbMem.exists(32'h200) || tbMem[32'h200] !== 32'h55) begin
      nErr++;
      $display("FAIL sim_store_written: memory word 200 not 55");
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    int nd;
    logic [5:0] isFetch;
    nd = 0;
    accLog.delete();
    if_addr = 32'h1000;
    if_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h2000;
    dm_req = 1'b1;
    for (int c = 0; c < 80 && accLog.size() < 6; c++) begin
      tick();
      if (dm_ready) begin
        nd++;
        dm_addr = 32'h2000 + 32'(4 * nd);
      end
      if (if_ready) if_req = 1'b0;
    end
    for (int c = 0; c < 20 && !dm_ready; c++) tick();
    dm_req = 1'b0;
    if_req = 1'b0;
    tick();
    nVec++;
    if (accLog.size() < 6) begin
      nErr++;
      $display("FAIL burst_progress: got %0d accesses want 6", accLog.size());
    end else begin
      for (int i = 0; i < 6; i++) isFetch[i] = accLog[i] == {1'b0, 32'h1000};
      nVec++;
      if (isFetch !== 6'b010000) begin
        nErr++;
        $display("FAIL burst_order: got fetch mask %b want 010000", isFetch);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    memOn = 1'b0;
    dm_we = 1'b0;
    dm_addr = 32'h300;
    dm_req = 1'b1;
    tick();
    while (mem_req === 1'b1 && n < 30) begin
      n++;
      tick();
    end
    nVec++;
    if (n != TMO) begin
      nErr++;
      $display("FAIL tmo_busy_cycles: got %0d want %0d", n, TMO);
    end
    nVec++;
    if ({dm_ready, arb_err, dm_rdata} !== {2'b11, 32'h0}) begin
      nErr++;
      $display("FAIL tmo_abort: got ready %b err %b data %h want 1 1 0", dm_ready, arb_err, dm_rdata);
    end
    dm_req = 1'b0;
    memOn = 1'b1;
    forceAck = 1'b1;
    tick();
    forceAck = 1'b0;
    tick();
    nVec++;
    if ({dm_ready, if_ready, mem_req, arb_err} !== 4'b0001) begin
      nErr++;
      $display("FAIL tmo_late_ack: got dm/if/req/err %b want 0001", {dm_ready, if_ready, mem_req, arb_err});
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    memWait = 3;
    dm_we = 1'b0;
    dm_addr = 32'h400;
    dm_req = 1'b1;
    tick();
    tick();
    nVec++;
    if (mem_req !== 1'b1) begin
      nErr++;
      $display("FAIL rst_mid_busy: got mem_req %b want 1", mem_req);
    end
    #1 reset = 1'b1;
    #1;
    nVec++;
    if ({mem_req, mem_we, if_ready, dm_ready, arb_err, mem_addr, dm_rdata} !== '0) begin
      nErr++;
      $display("FAIL rst_mid_async: got req %b we %b err %b addr %h want all 0", mem_req, mem_we, arb_err, mem_addr);
    end
    dm_req = 1'b0;
    tick();
    reset = 1'b0;
    forceAck = 1'b1;
    tick();
    forceAck = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      seen = seen | dm_ready | if_ready | mem_req;
    end
    nVec++;
    if (seen !== 1'b0) begin
      nErr++;
      $display("FAIL rst_mid_no_ready: got activity %b want 0", seen);
    end
    memWait = 0;
  endtask

  task automatic test_random();
    int dmAge, ifAge, pend, seen, dmDone, ifDone;
    logic [DW-1:0] lastDm, exp;
    bit issue;
    dmAge = 0;
    ifAge = 0;
    pend = 0;
    seen = 0;
    dmDone = 0;
    ifDone = 0;
    lastDm = '0;
    accLog.delete();
    randWait = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      issue = c < 2500;
      tick();
      while (seen < accLog.size()) begin
        if (accLog[seen][AW-1:0] >= 32'h2000) begin
          if (if_req) begin
            pend++;
            nVec++;
            if (pend > MAXB) begin
              nErr++;
              $display("FAIL rnd_burst: got %0d data grants while fetch pending want <= %0d", pend, MAXB);
            end
          end
        end else pend = 0;
        seen++;
      end
      if (dm_ready) begin
        nVec++;
        if (!dm_req) begin
          nErr++;
          $display("FAIL rnd_dm_spurious: got dm_ready with no request want 0");
        end else begin
          exp = dm_we ? lastDm : refRead(dm_addr);
          if (dm_rdata !== exp) begin
            nErr++;
            $display("FAIL rnd_dm_rdata: addr %h we %b got %h want %h", dm_addr, dm_we, dm_rdata, exp);
          end
          if (dm_we) refMem[dm_addr] = dm_wdata;
          else lastDm = exp;
          dmDone++;
          dm_req = 1'b0;
        end
      end
      if (if_ready) begin
        nVec++;
        if (!if_req) begin
          nErr++;
          $display("FAIL rnd_if_spurious: got if_ready with no request want 0");
        end else begin
          exp = refRead(if_addr);
          if (if_rdata !== exp) begin
            nErr++;
            $display("FAIL rnd_if_rdata: addr %h got %h want %h", if_addr, if_rdata, exp);
          end
          ifDone++;
          if_req = 1'b0;
        end
      end
      dmAge = dm_req ? dmAge + 1 : 0;
      ifAge = if_req ? ifAge + 1 : 0;
      if (dmAge > 60 || ifAge > 60) begin
        nVec++;
        nErr++;
        $display("FAIL rnd_starve: got wait dm %0d if %0d want <= 60", dmAge, ifAge);
        break;
      end
      if (issue && !dm_req && $urandom_range(0, 2) == 0) begin
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'h2000 + 32'(4 * $urandom_range(0, 15));
        dm_wdata = $urandom;
        dm_req = 1'b1;
      end
      if (issue && !if_req && $urandom_range(0, 1) == 0) begin
        if_addr = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        if_req = 1'b1;
      end
      if (!if_req) pend = 0;
      if (!issue && !dm_req && !if_req) break;
    end
    randWait = 1'b0;
    memWait = 0;
    dm_req = 1'b0;
    if_req = 1'b0;
    tick();
    tick();
    nVec++;
    if (dmDone + ifDone < 100 || arb_err !== 1'b0) begin
      nErr++;
      $display("FAIL rnd_progress: got %0d completions err %b want >= 100 and 0", dmDone + ifDone, arb_err);
    end
    nVec++;
`ifdef ARB_FETCH_BUF_EN
    if (accLog.size() > dmDone + ifDone) begin
`else
    if (accLog.size() != dmDone + ifDone) begin
`endif
      nErr++;
      $display("FAIL rnd_access_count: got %0d memory accesses for %0d completions", accLog.size(), dmDone + ifDone);
    end
  endtask

`ifdef ARB_FETCH_BUF_EN
  task automatic test_fetch_buf();
    int nFetch;
    nFetch = 0;
    accLog.delete();
    if_addr = 32'h40;
    if_req = 1'b1;
    for (int c = 0; c < 12 && !if_ready; c++) tick();
    if_req = 1'b0;
    tick();
    if_req = 1'b1;
    tick();
    nVec++;
    if ({if_ready, if_rdata} !== {1'b1, refRead(32'h40)}) begin
      nErr++;
      $display("FAIL buf_hit: got ready %b data %h want 1 %h", if_ready, if_rdata, refRead(32'h40));
    end
    if_req = 1'b0;
    tick();
    nVec++;
    if (accLog.size() != 1) begin
      nErr++;
      $display("FAIL buf_one_access: got %0d accesses want 1", accLog.size());
    end
    dm_we = 1'b1;
    dm_addr = 32'h40;
    dm_wdata = 32'hA5A5_1234;
    dm_req = 1'b1;
    for (int c = 0; c < 12 && !dm_ready; c++) tick();
    refMem[32'h40] = 32'hA5A5_1234;
    dm_req = 1'b0;
    dm_we = 1'b0;
    if_req = 1'b1;
    tick();
    for (int c = 0; c < 12 && !if_ready; c++) tick();
    nVec++;
    if (if_rdata !== 32'hA5A5_1234) begin
      nErr++;
      $display("FAIL buf_after_store: got %h want a5a51234", if_rdata);
    end
    if_req = 1'b0;
    tick();
    foreach (accLog[i]) if (accLog[i] == {1'b0, 32'h40}) nFetch++;
    nVec++;
    if (nFetch != 2) begin
      nErr++;
      $display("FAIL buf_refetch: got %0d memory fetches want 2", nFetch);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_load();
    test_simultaneous();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_random();
`ifdef ARB_FETCH_BUF_EN
    test_fetch_buf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
